dma_mem_sched: RTL and testbench
================================

# dma_mem_sched

Two-channel scheduler that shares one test memory device between two DMA requesters. It arbitrates round-robin, loads the winner's command (direction, address, count, increment mode) onto the device's write or read control side, and generates a clean rising edge on the enable. It tracks completion, using write-finished for writes and observed read strobes for reads, then returns done or error to the requester. It sits between the DMA channel sequencers and the memory test device in the wishbone DMA simulation environment.

## Interface
- TIMEOUT_CYCLES, 1024: RUN-state cycle limit before abort (1..65535).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  2  per-channel request, level
- dir  in  2  per-channel direction: 1 = write into device, 0 = read from device
- addr  in  128  channel i address at [64*i+63:64*i]
- count  in  48  channel i word count at [24*i+23:24*i]
- inc  in  2  per-channel address increment
- dec  in  2  per-channel address decrement
- grant  out  2  one-hot ownership
- done  out  2  one-cycle completion pulse
- error  out  2  one-cycle timeout pulse, coincident with done
- write_enable, read_enable  out  1  device enables
- write_addr, read_addr  out  64  device start address
- write_addr_inc, write_addr_dec, read_addr_inc, read_addr_dec  out  1  address mode
- write_count, read_count  out  24  transfer length
- write_flush, read_flush  out  1  abort flush pulse
- write_finished  in  1  device write side complete
- read_strobe_mon  in  1  copy of the consumer's read strobe on the device read FIFO

## Operation
- States: IDLE, SETUP, RUN, DONE.
- IDLE:
  - If any req bit is high, select a channel and latch its dir/addr/count/inc/dec. Go to SETUP.
  - When both channels request, the one not granted last wins. The last-grant pointer resets to 1, so ch0 wins the first tie.
- SETUP (1 cycle):
  - grant[g]=1.
  - Drive the latched fields onto the side selected by dir. Hold the other side's fields at 0.
  - Both enables stay 0.
  - If inc and dec are both set, inc=1 and dec=0.
  - count==0: skip to DONE without raising enable.
- RUN:
  - Selected enable=1; all fields held stable.
  - Write completion: write_finished==1 with run_cnt>=2. The two-cycle window masks the stale finished value from the previous command.
  - Read completion: count read_strobe_mon pulses seen in RUN; complete when strobes_seen+read_strobe_mon==count.
  - On completion go to DONE.
- DONE (1 cycle):
  - Enable=0, done[g]=1, grant[g] stays 1.
  - Update the pointer to g, then go to IDLE.
- Read strobes outside RUN are ignored. The 24-bit strobe counter clears in SETUP.
- A requester must drop req by the cycle after done, or it re-enters arbitration. Dropping req before grant withdraws the request.
- Fields held by a requester need only be valid in the IDLE cycle where it is selected.

## Timing
- Reset values: all outputs 0; state IDLE; pointer 1; counters 0.
- Write side, req seen high at edge N:
  - Edge N: SETUP, grant valid, fields valid.
  - Edge N+1: RUN, enable=1.
  - Earliest done: edge N+3 (DONE), if write_finished is high at edge N+3.
  - Edge N+4: IDLE, grant=0.
  - Next grant: edge N+5 at the earliest.
- Read side: done asserts the edge after the count-th strobe is sampled. A count=1 read with the strobe in the first RUN cycle gives done at edge N+2.
- Zero count: SETUP at edge N, DONE at edge N+1, enable never rises.
- Reset mid-transfer: at the next edge all outputs are 0 and the transfer is abandoned with no done or error.

## Configuration
- DMA_MEM_SCHED_TIMEOUT_EN defined:
  - A 16-bit run_cnt saturates. Reaching TIMEOUT_CYCLES in RUN forces DONE with error[g]=1.
  - The active side's flush is pulsed for the DONE cycle.
- Undefined:
  - No timeout; run_cnt is used only for the 2-cycle write mask.
  - error and both flushes are tied to 0.

## Test plan
- Ch0 write, addr 0x10, count 8, inc → write_enable rises at N+1 with write_addr=0x10, write_count=8, write_addr_inc=1. Holding write_finished low for 5 RUN cycles, then high → done[0] one cycle later, grant[0] drops the following edge.
- Ch1 read, addr 0x20, count 4, dec, strobes on 4 non-consecutive cycles → read_addr_dec=1, read_enable stays high until the 4th strobe. done[1] comes on the next edge; write side stays 0 throughout.
- req=2'b11 held, both write count 1 → grants alternate ch0, ch1, ch0. No cycle has both grant bits set.
- Write with write_finished stuck high → no done before RUN cycle 3; done at N+3.
- With DMA_MEM_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read that never strobes → done[0] and error[0] together with a read_flush pulse 16 RUN cycles in. Without the macro the bench sees no done.
- rst asserted during RUN of a write → next edge write_enable=0, grant=0, no done. A fresh ch0 request after release is granted normally.

Source files
------------

// File: rtl/dma_mem_sched.sv
// Two-channel round-robin scheduler that shares one memory test device between DMA requesters.
// Optional RUN-state timeout with error/flush: define DMA_MEM_SCHED_TIMEOUT_EN.
module dma_mem_sched #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [1:0]   dir,
  input  logic [127:0] addr,
  input  logic [47:0]  count,
  input  logic [1:0]   inc,
  input  logic [1:0]   dec,
  output logic [1:0]   grant,
  output logic [1:0]   done,
  output logic [1:0]   error,
  output logic         write_enable,
  output logic         read_enable,
  output logic [63:0]  write_addr,
  output logic [63:0]  read_addr,
  output logic         write_addr_inc,
  output logic         write_addr_dec,
  output logic         read_addr_inc,
  output logic         read_addr_dec,
  output logic [23:0]  write_count,
  output logic [23:0]  read_count,
  output logic         write_flush,
  output logic         read_flush,
  input  logic         write_finished,
  input  logic         read_strobe_mon
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

`ifdef DMA_MEM_SCHED_TIMEOUT_EN
  localparam int RC_W = 16;
`else
  localparam int RC_W = 2;
`endif

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dma_mem_sched: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t            state_q, state_d;
  logic              ptr_q, sel_q, dir_q, inc_q, dec_q;
  logic [63:0]       addr_q;
  logic [23:0]       count_q, strb_q;
  logic [RC_W-1:0]   run_cnt_q;
  logic              pick, complete, timeout;

  // Tie goes to the channel not granted last; a lone requester always wins.
  assign pick = (req == 2'b11) ? ~ptr_q : req[1];

  always_comb begin
    if (dir_q) complete = write_finished && (run_cnt_q >= RC_W'(2));
    else       complete = (strb_q + {23'd0, read_strobe_mon}) == count_q;
  end

`ifdef DMA_MEM_SCHED_TIMEOUT_EN
  logic err_q;
  assign timeout = (run_cnt_q >= RC_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = SETUP;
      SETUP:   state_d = (count_q == 24'd0) ? DONE : RUN;
      RUN:     if (complete || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 1'b1;
      sel_q     <= 1'b0;
      dir_q     <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      addr_q    <= 64'd0;
      count_q   <= 24'd0;
      strb_q    <= 24'd0;
      run_cnt_q <= '0;
`ifdef DMA_MEM_SCHED_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && |req) begin
        sel_q   <= pick;
        dir_q   <= dir[pick];
        addr_q  <= pick ? addr[127:64] : addr[63:0];
        count_q <= pick ? count[47:24] : count[23:0];
        inc_q   <= inc[pick];
        dec_q   <= dec[pick] & ~inc[pick];
      end
      if (state_q == SETUP) begin
        run_cnt_q <= RC_W'(1);
        strb_q    <= 24'd0;
      end else if (state_q == RUN) begin
        if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + 1'b1;
        if (read_strobe_mon) strb_q <= strb_q + 24'd1;
      end
      if (state_q == DONE) ptr_q <= sel_q;
`ifdef DMA_MEM_SCHED_TIMEOUT_EN
      err_q <= (state_q == RUN) && timeout && !complete;
`endif
    end
  end

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant          = 2'b00;
    done           = 2'b00;
    error          = 2'b00;
    write_enable   = 1'b0;
    read_enable    = 1'b0;
    write_addr     = 64'd0;
    read_addr      = 64'd0;
    write_addr_inc = 1'b0;
    write_addr_dec = 1'b0;
    read_addr_inc  = 1'b0;
    read_addr_dec  = 1'b0;
    write_count    = 24'd0;
    read_count     = 24'd0;
    write_flush    = 1'b0;
    read_flush     = 1'b0;
    if (state_q != IDLE) begin
      grant[sel_q] = 1'b1;
      if (dir_q) begin
        write_addr     = addr_q;
        write_count    = count_q;
        write_addr_inc = inc_q;
        write_addr_dec = dec_q;
        write_enable   = (state_q == RUN);
      end else begin
        read_addr     = addr_q;
        read_count    = count_q;
        read_addr_inc = inc_q;
        read_addr_dec = dec_q;
        read_enable   = (state_q == RUN);
      end
    end
    if (state_q == DONE) begin
      done[sel_q] = 1'b1;
`ifdef DMA_MEM_SCHED_TIMEOUT_EN
      error[sel_q] = err_q;
      write_flush  = err_q & dir_q;
      read_flush   = err_q & ~dir_q;
`endif
    end
  end

endmodule

// File: tb/tb_dma_mem_sched.sv
// Self-checking bench for dma_mem_sched: directed scenarios plus randomized commands
// checked against a cycle-rule reference model of the scheduler.
module tb_dma_mem_sched;

  localparam int TO = 16;
`ifdef DMA_MEM_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk, rst;
  logic [1:0]   req, dir, inc, dec;
  logic [127:0] addr;
  logic [47:0]  count;
  logic [1:0]   grant, done, error;
  logic         write_enable, read_enable;
  logic [63:0]  write_addr, read_addr;
  logic         write_addr_inc, write_addr_dec, read_addr_inc, read_addr_dec;
  logic [23:0]  write_count, read_count;
  logic         write_flush, read_flush;
  logic         write_finished, read_strobe_mon;

  int n_checks = 0;
  int n_fail   = 0;

  dma_mem_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .addr(addr), .count(count),
    .inc(inc), .dec(dec), .grant(grant), .done(done), .error(error),
    .write_enable(write_enable), .read_enable(read_enable),
    .write_addr(write_addr), .read_addr(read_addr),
    .write_addr_inc(write_addr_inc), .write_addr_dec(write_addr_dec),
    .read_addr_inc(read_addr_inc), .read_addr_dec(read_addr_dec),
    .write_count(write_count), .read_count(read_count),
    .write_flush(write_flush), .read_flush(read_flush),
    .write_finished(write_finished), .read_strobe_mon(read_strobe_mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [189:0] obs;
  assign obs = {grant, done, error, write_enable, read_enable,
                write_addr_inc, write_addr_dec, read_addr_inc, read_addr_dec,
                write_flush, read_flush, write_addr, read_addr, write_count, read_count};

  // Expected output bundle while channel ch owns the device with the given command.
  function automatic logic [189:0] expv(int ch, bit d, logic [63:0] a, logic [23:0] c,
                                        bit i, bit dd, bit en, bit dn, bit er);
    logic [1:0] g;
    logic       dn_eff;
    g = (ch == 0) ? 2'b01 : 2'b10;
    dn_eff = dd & ~i;
    return {g, dn ? g : 2'b00, er ? g : 2'b00, d & en, ~d & en,
            d & i, d & dn_eff, ~d & i, ~d & dn_eff, d & er, ~d & er,
            d ? a : 64'd0, d ? 64'd0 : a, d ? c : 24'd0, d ? 24'd0 : c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    write_finished = 1'b0;
    read_strobe_mon = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic scramble_fields();
    dir   = 2'($urandom);
    inc   = 2'($urandom);
    dec   = 2'($urandom);
    addr  = {$urandom, $urandom, $urandom, $urandom};
    count = {16'($urandom), $urandom};
  endtask

  // One command on a single channel. wf_at: RUN cycle where write_finished rises;
  // stale drives it high in SETUP and RUN cycle 1; pct<0 strobes on even RUN cycles.
  task automatic drive_txn(input int ch, input bit d, input logic [63:0] a, input logic [23:0] c,
                           input bit i, input bit dd, input int wf_at, input bit stale,
                           input int pct, input string tag);
    int r, seen;
    bit fin, cmpl, to, wf, sb;
    req[ch] = 1'b1;
    dir[ch] = d;
    inc[ch] = i;
    dec[ch] = dd;
    addr[64*ch +: 64] = a;
    count[24*ch +: 24] = c;
    tick();
    n_checks++;
    if (obs !== expv(ch, d, a, c, i, dd, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL %s setup: got %h want %h", tag, obs, expv(ch, d, a, c, i, dd, 0, 0, 0));
    end
    req[ch] = 1'b0;
    scramble_fields();
    read_strobe_mon = 1'b1;
    write_finished = stale;
    tick();
    r = 1; seen = 0; fin = 0; to = 0;
    if (c != 24'd0) begin
      while (!fin && r <= 300) begin
        n_checks++;
        if (obs !== expv(ch, d, a, c, i, dd, 1, 0, 0)) begin
          n_fail++;
          $display("FAIL %s run%0d: got %h want %h", tag, r, obs, expv(ch, d, a, c, i, dd, 1, 0, 0));
        end
        wf = (r >= wf_at) || (r == 1 && stale);
        sb = (pct < 0) ? (r % 2 == 0) : ($urandom_range(99) < pct);
        write_finished = wf;
        read_strobe_mon = sb;
        cmpl = d ? (wf && r >= 2) : (seen + int'(sb) == int'(c));
        to = TO_EN && (r >= TO) && !cmpl;
        tick();
        if (cmpl || to) fin = 1;
        else begin
          seen += int'(sb);
          r++;
        end
      end
      if (!fin) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s completion: got no completion after %0d RUN cycles, want completion", tag, r);
      end
    end
    n_checks++;
    if (obs !== expv(ch, d, a, c, i, dd, 0, 1, to)) begin
      n_fail++;
      $display("FAIL %s done: got %h want %h", tag, obs, expv(ch, d, a, c, i, dd, 0, 1, to));
    end
    write_finished = 1'b0;
    read_strobe_mon = 1'b0;
    tick();
    n_checks++;
    if (obs !== 190'd0) begin
      n_fail++;
      $display("FAIL %s idle: got %h want 0", tag, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b11;
    scramble_fields();
    write_finished = 1'b1;
    read_strobe_mon = 1'b1;
    tick();
    n_checks++;
    if (obs !== 190'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    req = 2'b00;
    write_finished = 1'b0;
    read_strobe_mon = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs !== 190'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h want 0", obs);
    end
  endtask

  task automatic test_write();
    drive_txn(0, 1, 64'h10, 24'd8, 1, 0, 6, 0, 0, "write_ch0");
  endtask

  task automatic test_read();
    drive_txn(1, 0, 64'h20, 24'd4, 0, 1, 1000, 0, -1, "read_ch1");
  endtask

  task automatic test_stuck_finished();
    drive_txn(0, 1, 64'hABC0, 24'd3, 1, 1, 1, 1, 0, "wf_stuck");
    drive_txn(1, 1, 64'h77, 24'd0, 0, 0, 1, 1, 100, "zero_count_w");
    drive_txn(0, 0, 64'h88, 24'd0, 1, 0, 1, 0, 100, "zero_count_r");
    drive_txn(0, 0, 64'h99, 24'd1, 0, 0, 1000, 0, 100, "read_one");
  endtask

  task automatic test_round_robin();
    int w;
    logic [1:0] want;
    do_reset();
    dir = 2'b11; inc = 2'b11; dec = 2'b00;
    addr = {64'h200, 64'h100};
    count = {24'd1, 24'd1};
    write_finished = 1'b1;
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      while (grant === 2'b00 && w < 10) begin tick(); w++; end
      n_checks++;
      if (grant !== want) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", k, grant, want);
      end
      w = 0;
      while (done === 2'b00 && w < 10) begin
        n_checks++;
        if (grant === 2'b11) begin
          n_fail++;
          $display("FAIL rr_onehot: got %b want one-hot", grant);
        end
        tick();
        w++;
      end
      n_checks++;
      if (done !== want) begin
        n_fail++;
        $display("FAIL rr_done%0d: got %b want %b", k, done, want);
      end
      tick();
    end
    req = 2'b00;
    write_finished = 1'b0;
    for (int k = 0; k < 6 && grant !== 2'b00; k++) tick();
    n_checks++;
    if (obs !== 190'd0) begin
      n_fail++;
      $display("FAIL rr_idle: got %h want 0", obs);
    end
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef DMA_MEM_SCHED_TIMEOUT_EN
    drive_txn(0, 0, 64'h40, 24'd5, 1, 0, 1000, 0, 0, "timeout");
`else
    req[0] = 1'b1; dir[0] = 1'b0; inc[0] = 1'b1; dec[0] = 1'b0;
    addr[63:0] = 64'h40; count[23:0] = 24'd5;
    tick();
    req[0] = 1'b0;
    tick();
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (obs !== expv(0, 0, 64'h40, 24'd5, 1, 0, 1, 0, 0)) begin
        n_fail++;
        $display("FAIL no_timeout%0d: got %h want %h", k, obs, expv(0, 0, 64'h40, 24'd5, 1, 0, 1, 0, 0));
      end
      tick();
    end
    do_reset();
`endif
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req[0] = 1'b1; dir[0] = 1'b1; inc[0] = 1'b1; dec[0] = 1'b0;
    addr[63:0] = 64'h55; count[23:0] = 24'd8;
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (write_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_enable: got %b want 1", write_enable);
    end
    write_finished = 1'b1;
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 190'd0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got %h want 0", obs);
    end
    rst = 1'b0;
    write_finished = 1'b0;
    tick();
    n_checks++;
    if (obs !== 190'd0) begin
      n_fail++;
      $display("FAIL mid_run_after: got %h want 0", obs);
    end
    drive_txn(0, 1, 64'h66, 24'd2, 0, 1, 3, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      drive_txn($urandom_range(1), 1'($urandom), {$urandom, $urandom},
                ($urandom_range(9) == 0) ? 24'd0 : 24'($urandom_range(6, 1)),
                1'($urandom), 1'($urandom), $urandom_range(6, 1), 1'($urandom),
                $urandom_range(100, 40), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req = 2'b00;
    dir = 2'b00; inc = 2'b00; dec = 2'b00;
    addr = '0; count = '0;
    write_finished = 1'b0;
    read_strobe_mon = 1'b0;
    rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_stuck_finished();
    test_round_robin();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
